// File: rtl/hs_angle_sequencer.sv
// hs_angle_sequencer: multi-lane projection-angle source.
// Each beat carries NUM_CH angles: base, base+step, ... Lanes at or past the
// exclusive end code are masked and driven to zero. The end code is clamped
// to ANGLE_END. The beat stream uses a valid/ready handshake.
// Optional feature macro: HS_ANGLE_SEQ_REPEAT_EN (continuous rotation via cfg_repeat).
module hs_angle_sequencer #(
    parameter int ANGLE_W   = 12,
    parameter int NUM_CH    = 4,
    parameter int ANGLE_END = 1800
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [ANGLE_W-1:0]          cfg_start,
    input  logic [ANGLE_W-1:0]          cfg_step,
    input  logic [ANGLE_W-1:0]          cfg_end,
`ifdef HS_ANGLE_SEQ_REPEAT_EN
    input  logic                        cfg_repeat,
`endif
    input  logic                        start,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [NUM_CH*ANGLE_W-1:0]   out_angle,
    output logic [NUM_CH-1:0]           out_mask,
    output logic                        busy,
    output logic                        done,
    output logic                        cfg_err
);

    // Sums carry headroom so base + lane*step can never wrap into a lane.
    localparam int SUM_W = ANGLE_W + $clog2(NUM_CH) + 1;
    localparam logic [SUM_W-1:0] END_LIM = SUM_W'(ANGLE_END);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [SUM_W-1:0]   base_q, base_d;
    logic [ANGLE_W-1:0] step_q, step_d;
    logic [SUM_W-1:0]   end_q, end_d;
    logic               cfg_err_q, cfg_err_d;
    logic               done_q, done_d;

`ifdef HS_ANGLE_SEQ_REPEAT_EN
    logic [ANGLE_W-1:0] start_q, start_d;
    logic               repeat_q, repeat_d;
    logic               stop_q, stop_d;
    logic               seen_done_q, seen_done_d;
`endif

    logic [SUM_W-1:0]   lane_sum [NUM_CH];
    logic [SUM_W-1:0]   next_base;
    logic [SUM_W-1:0]   end_eff_in;
    logic               accept;

    // Lane angles, lane mask and the handshake outputs derived from the registered base.
    always_comb begin
        out_angle = '0;
        out_mask  = '0;
        out_valid = (state_q == S_RUN);
        for (int i = 0; i < NUM_CH; i++) begin
            lane_sum[i] = base_q + SUM_W'(i) * SUM_W'(step_q);
            if (out_valid && (lane_sum[i] < end_q)) begin
                out_mask[i]                     = 1'b1;
                out_angle[i*ANGLE_W +: ANGLE_W] = lane_sum[i][ANGLE_W-1:0];
            end
        end
        next_base  = base_q + SUM_W'(NUM_CH) * SUM_W'(step_q);
        end_eff_in = (SUM_W'(cfg_end) > END_LIM) ? END_LIM : SUM_W'(cfg_end);
        accept     = out_valid && out_ready;
        busy       = (state_q != S_IDLE);
        done       = done_q;
        cfg_err    = cfg_err_q;
    end

    // Next-state logic: config capture in IDLE, base advance on accept, end-of-pass handling.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        step_d    = step_q;
        end_d     = end_q;
        cfg_err_d = 1'b0;
        done_d    = 1'b0;
`ifdef HS_ANGLE_SEQ_REPEAT_EN
        start_d     = start_q;
        repeat_d    = repeat_q;
        stop_d      = stop_q;
        seen_done_d = seen_done_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d = SUM_W'(cfg_start);
                    step_d = cfg_step;
                    end_d  = end_eff_in;
`ifdef HS_ANGLE_SEQ_REPEAT_EN
                    start_d     = cfg_start;
                    repeat_d    = cfg_repeat;
                    stop_d      = 1'b0;
                    seen_done_d = 1'b0;
`endif
                    if ((cfg_step == '0) || (SUM_W'(cfg_start) >= end_eff_in)) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
`ifdef HS_ANGLE_SEQ_REPEAT_EN
                if (start && seen_done_q) begin
                    stop_d = 1'b1;
                end
`endif
                if (accept) begin
                    base_d = next_base;
                    if (next_base >= end_q) begin
                        done_d = 1'b1;
`ifdef HS_ANGLE_SEQ_REPEAT_EN
                        if (repeat_q && !stop_q) begin
                            base_d      = SUM_W'(start_q);
                            seen_done_d = 1'b1;
                        end else begin
                            state_d = S_DONE;
                        end
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any sequence without a done pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            step_q    <= '0;
            end_q     <= '0;
            cfg_err_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef HS_ANGLE_SEQ_REPEAT_EN
            start_q     <= '0;
            repeat_q    <= 1'b0;
            stop_q      <= 1'b0;
            seen_done_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            step_q    <= step_d;
            end_q     <= end_d;
            cfg_err_q <= cfg_err_d;
            done_q    <= done_d;
`ifdef HS_ANGLE_SEQ_REPEAT_EN
            start_q     <= start_d;
            repeat_q    <= repeat_d;
            stop_q      <= stop_d;
            seen_done_q <= seen_done_d;
`endif
        end
    end

endmodule

// File: tb/tb_hs_angle_sequencer.sv
// Testbench for hs_angle_sequencer: a scoreboard queue of expected beats is
// filled from a reference model when a sequence is started and drained as
// the DUT hands beats over.
module tb_hs_angle_sequencer;

    localparam int W = 12;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [W-1:0]     cfg_start;
    logic [W-1:0]     cfg_step;
    logic [W-1:0]     cfg_end;
`ifdef HS_ANGLE_SEQ_REPEAT_EN
    logic             cfg_repeat;
`endif
    logic             start;
    logic             out_ready;
    logic             out_valid;
    logic [N*W-1:0]   out_angle;
    logic [N-1:0]     out_mask;
    logic             busy;
    logic             done;
    logic             cfg_err;

    typedef struct {
        logic [N*W-1:0] angle;
        logic [N-1:0]   mask;
    } beat_t;

    beat_t expq[$];
    int    vectors     = 0;
    int    miscompares = 0;

    always #5 clk = ~clk;

    hs_angle_sequencer #(.ANGLE_W(W), .NUM_CH(N), .ANGLE_END(1800)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_start (cfg_start),
        .cfg_step  (cfg_step),
        .cfg_end   (cfg_end),
`ifdef HS_ANGLE_SEQ_REPEAT_EN
        .cfg_repeat(cfg_repeat),
`endif
        .start     (start),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_angle (out_angle),
        .out_mask  (out_mask),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one full pass of beats for the given configuration.
    task automatic pushPass(input int s, input int st, input int e);
        int eff;
        eff = (e > 1800) ? 1800 : e;
        for (int b = s; b < eff; b += N * st) begin
            beat_t x;
            x.angle = '0;
            x.mask  = '0;
            for (int i = 0; i < N; i++) begin
                int v;
                v = b + i * st;
                if (v < eff) begin
                    x.angle[i*W +: W] = W'(v);
                    x.mask[i]         = 1'b1;
                end
            end
            expq.push_back(x);
        end
    endtask

    task automatic applyStimulus(input int s, input int st, input int e, input bit rep);
        cfg_start = W'(s);
        cfg_step  = W'(st);
        cfg_end   = W'(e);
`ifdef HS_ANGLE_SEQ_REPEAT_EN
        cfg_repeat = rep;
`else
        if (rep) $display("[TB] repeat request ignored in single-pass build");
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Consume beats from the DUT; mode 0 = ready always, mode 1 = ready toggles.
    task automatic drainBeats(input int mode, input int max_beats, input bit pulse_start);
        int          cyc;
        int          taken;
        bit          hold_pending;
        logic [N*W-1:0] held_angle;
        logic [N-1:0]   held_mask;
        cyc          = 0;
        taken        = 0;
        hold_pending = 1'b0;
        held_angle   = '0;
        held_mask    = '0;
        while ((expq.size() > 0) && (taken < max_beats) && (cyc < 400)) begin
            start     = (cyc == 0) ? pulse_start : 1'b0;
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            checkOutput("valid_no_bubble", 64'(out_valid), 64'd1);
            if (hold_pending) begin
                checkOutput("hold_angle", 64'(out_angle), 64'(held_angle));
                checkOutput("hold_mask", 64'(out_mask), 64'(held_mask));
            end
            if (out_valid && out_ready) begin
                beat_t b;
                b = expq.pop_front();
                checkOutput("beat_angle", 64'(out_angle), 64'(b.angle));
                checkOutput("beat_mask", 64'(out_mask), 64'(b.mask));
                taken++;
                hold_pending = 1'b0;
            end else begin
                held_angle   = out_angle;
                held_mask    = out_mask;
                hold_pending = 1'b1;
            end
            tick();
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        checkOutput("beat_budget", 64'(cyc < 400), 64'd1);
    endtask

    task automatic checkDone();
        checkOutput("beats_left", 64'(expq.size()), 64'd0);
        checkOutput("done_pulse", 64'(done), 64'd1);
        checkOutput("valid_after_last", 64'(out_valid), 64'd0);
        tick();
        checkOutput("done_clear", 64'(done), 64'd0);
        checkOutput("busy_clear", 64'(busy), 64'd0);
    endtask

    task automatic checkReject(input string tag);
        checkOutput({tag, "_err"}, 64'(cfg_err), 64'd1);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_valid"}, 64'(out_valid), 64'd0);
        tick();
        checkOutput({tag, "_err_clear"}, 64'(cfg_err), 64'd0);
        checkOutput({tag, "_busy2"}, 64'(busy), 64'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        cfg_start = '0;
        cfg_step  = '0;
        cfg_end   = '0;
`ifdef HS_ANGLE_SEQ_REPEAT_EN
        cfg_repeat = 1'b0;
`endif
        tick();
        tick();
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_mask", 64'(out_mask), 64'd0);
        checkOutput("rst_angle", 64'(out_angle), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_err", 64'(cfg_err), 64'd0);
        reset_n = 1'b1;
        tick();

        // Full-rate stream: five beats, partial last beat.
        pushPass(0, 100, 1800);
        applyStimulus(0, 100, 1800, 1'b0);
        checkOutput("busy_run", 64'(busy), 64'd1);
        drainBeats(0, 1000, 1'b0);
        checkDone();

        // Same stream with ready toggling every cycle.
        pushPass(0, 100, 1800);
        applyStimulus(0, 100, 1800, 1'b0);
        drainBeats(1, 1000, 1'b0);
        checkDone();

        // Rejected configurations.
        applyStimulus(0, 0, 1800, 1'b0);
        checkReject("step0");
        applyStimulus(1800, 10, 1800, 1'b0);
        checkReject("start_eq_end");

        // End code clamped to 1800: single partial beat.
        pushPass(1700, 60, 4000);
        applyStimulus(1700, 60, 4000, 1'b0);
        drainBeats(0, 1000, 1'b0);
        checkDone();

        // Reset mid-sequence while beat 2 is presented, then a fresh run.
        pushPass(0, 100, 1800);
        applyStimulus(0, 100, 1800, 1'b0);
        drainBeats(0, 2, 1'b0);
        checkOutput("pre_abort_valid", 64'(out_valid), 64'd1);
        reset_n = 1'b0;
        tick();
        checkOutput("abort_valid", 64'(out_valid), 64'd0);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        reset_n = 1'b1;
        expq.delete();
        tick();
        checkOutput("abort_no_done", 64'(done), 64'd0);
        pushPass(0, 100, 1800);
        applyStimulus(0, 100, 1800, 1'b0);
        drainBeats(0, 1000, 1'b0);
        checkDone();

`ifdef HS_ANGLE_SEQ_REPEAT_EN
        // Continuous rotation: done each pass, no bubble, stop after start.
        pushPass(0, 450, 1800);
        applyStimulus(0, 450, 1800, 1'b1);
        drainBeats(0, 1000, 1'b0);
        checkOutput("rep_done1", 64'(done), 64'd1);
        checkOutput("rep_valid1", 64'(out_valid), 64'd1);
        pushPass(0, 450, 1800);
        drainBeats(0, 1000, 1'b0);
        checkOutput("rep_done2", 64'(done), 64'd1);
        checkOutput("rep_valid2", 64'(out_valid), 64'd1);
        pushPass(0, 450, 1800);
        drainBeats(0, 1000, 1'b1);
        checkDone();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
